// File: rtl/fp_exp_arbiter_pkg.sv
// rtl/fp_exp_arbiter_pkg.sv - shared constants, tag type and round-robin pick for fp_exp_arbiter
// The grant search runs over NUM_REQ_MAX bits; unused requester bits are tied low by the caller.
package fp_exp_arb_pkg;

  localparam int FP_EXP_LATENCY = 17;
  localparam int NUM_REQ_MAX    = 8;

  typedef logic [$clog2(NUM_REQ_MAX)-1:0] tag_t;

  // Zero bits above NUM_REQ make a mod-8 search order identical to a mod-NUM_REQ one.
  function automatic logic [NUM_REQ_MAX-1:0] rr_pick(input logic [NUM_REQ_MAX-1:0] valid,
                                                     input tag_t ptr);
    logic [NUM_REQ_MAX-1:0] grant;
    tag_t idx;
    grant = '0;
    for (int k = NUM_REQ_MAX - 1; k >= 0; k--) begin
      idx = ptr + tag_t'(k);
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/fp_exp_arbiter_if.sv
// rtl/fp_exp_arbiter_if.sv - requester, exponent-unit and result streams of fp_exp_arbiter
// master is the surrounding environment, slave is the arbiter.
interface fp_exp_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;

  logic                           exp_snk_valid;
  logic [DATA_W-1:0]              exp_snk_data;
  logic                           exp_snk_ready;

  logic                           exp_src_valid;
  logic [DATA_W-1:0]              exp_src_data;
  logic                           exp_src_ready;

  logic [NUM_REQ-1:0]             res_valid;
  logic [DATA_W-1:0]              res_data;
  logic [NUM_REQ-1:0]             res_ready;

  modport master (
    output req_valid, req_data, exp_snk_ready, exp_src_valid, exp_src_data, res_ready,
    input  req_ready, exp_snk_valid, exp_snk_data, exp_src_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_data, exp_snk_ready, exp_src_valid, exp_src_data, res_ready,
    output req_ready, exp_snk_valid, exp_snk_data, exp_src_ready, res_valid, res_data
  );
endinterface

// File: rtl/fp_exp_arbiter_tag_fifo.sv
// rtl/fp_exp_arbiter_tag_fifo.sv - in-order register FIFO holding requester tags of in-flight operands
// Push into a full FIFO is accepted when a pop happens in the same cycle.
module tag_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_pop_en  = pop && !empty;
  assign w_push_en = push && (!full || w_pop_en);

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fp_exp_arbiter.sv
// rtl/fp_exp_arbiter.sv - round-robin share of one exponent pipeline among NUM_REQ requesters
// Optional FP_EXP_ARB_STATS_EN adds per-requester grant counters and an in-flight high-water mark.
module fp_exp_arbiter
  import fp_exp_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  fp_exp_arb_if.slave              bus,
  output logic                     orphan_err
`ifdef FP_EXP_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] grant_cnt,
  output logic [$clog2(TAG_DEPTH):0] max_inflight
`endif
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic                   r_or_valid;
  logic [DATA_W-1:0]      r_or_data;
  tag_t                   r_rr_ptr;
  logic                   r_orphan;

  logic                   w_or_can_load;
  logic                   w_issue_en;
  logic                   w_accept;
  logic [NUM_REQ_MAX-1:0] w_grant_all;
  logic [NUM_REQ-1:0]     w_grant;
  tag_t                   w_gidx;
  tag_t                   w_next_ptr;
  logic [DATA_W-1:0]      w_issue_data;

  logic                   w_tag_full;
  logic                   w_tag_empty;
  logic [CW-1:0]          w_tag_count;
  tag_t                   w_head;
  logic                   w_head_ready;
  logic                   w_pop;

  assign w_or_can_load = !r_or_valid || bus.exp_snk_ready;
  assign w_grant_all   = rr_pick(NUM_REQ_MAX'(bus.req_valid), r_rr_ptr);
  assign w_grant       = w_grant_all[NUM_REQ-1:0];
  assign w_issue_en    = w_or_can_load && !w_tag_full;
  assign bus.req_ready = w_issue_en ? w_grant : '0;
  assign w_accept      = w_issue_en && (|w_grant);
  assign w_next_ptr    = (w_gidx == tag_t'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

  always_comb begin
    w_gidx       = '0;
    w_issue_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx       = tag_t'(i);
        w_issue_data = bus.req_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_rr_ptr   <= '0;
      r_orphan   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_or_valid <= 1'b1;
        r_or_data  <= w_issue_data;
        r_rr_ptr   <= w_next_ptr;
      end else if (bus.exp_snk_ready) begin
        r_or_valid <= 1'b0;
      end
      if (bus.exp_src_valid && w_tag_empty) r_orphan <= 1'b1;
    end
  end

  assign bus.exp_snk_valid = r_or_valid;
  assign bus.exp_snk_data  = r_or_data;
  assign orphan_err        = r_orphan;

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH ($bits(tag_t))
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .push_data (w_gidx),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_tag_full),
    .empty     (w_tag_empty),
    .count     (w_tag_count)
  );

  // With no tag outstanding, a result is an orphan and is swallowed.
  always_comb begin
    w_head_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.res_valid[i] = bus.exp_src_valid && !w_tag_empty && (w_head == tag_t'(i));
      if (w_head == tag_t'(i)) w_head_ready = bus.res_ready[i];
    end
  end

  assign bus.res_data      = bus.exp_src_data;
  assign bus.exp_src_ready = w_tag_empty ? bus.exp_src_valid : w_head_ready;
  assign w_pop             = bus.exp_src_valid && !w_tag_empty && w_head_ready;

`ifdef FP_EXP_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] r_grant_cnt;
  logic [CW-1:0]            r_max_inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt    <= '0;
      r_max_inflight <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && w_grant[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
      if (w_tag_count > r_max_inflight) r_max_inflight <= w_tag_count;
    end
  end

  assign grant_cnt    = r_grant_cnt;
  assign max_inflight = r_max_inflight;
`else
  logic w_unused_count;
  assign w_unused_count = ^w_tag_count;
`endif

endmodule

// File: tb/tb_fp_exp_arbiter.sv
// tb/tb_fp_exp_arbiter.sv - scoreboard bench for fp_exp_arbiter with a fixed-latency exponent model
// Results are a byte-swizzle of the operand so routing and ordering errors show up in the data.
module tb_fp_exp_arbiter;
  import fp_exp_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [31:0] d;
    int          rdy;
  } mdl_t;

  logic clk = 1'b0;
  logic rst;
  logic orphan_err;

  always #5 clk = ~clk;

  fp_exp_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fp_exp_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .TAG_DEPTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .orphan_err (orphan_err)
  );

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          rem [NR];
  int          seq [NR];
  int          res_cnt [NR];
  int          n_acc = 0;
  bit          rst_req, inject, snk_mode, res_rdy;
  sb_t         sb [$];
  mdl_t        mdl [$];
  int          grant_log [$];
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [NR-1:0] last_req_ready;
  logic        last_src_ready;
  bit          src_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_f(input logic [31:0] d);
    return {d[15:0], d[31:16]} ^ 32'h3C3C_C3C3;
  endfunction

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || (mdl.size() != 0);
    for (int i = 0; i < NR; i++) if (rem[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    rst = rst_req;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = (rem[i] > 0);
      bus.req_data[i]  = {8'(i), 24'(seq[i])};
    end
    bus.exp_snk_ready = snk_mode ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
    if (inject) begin
      bus.exp_src_valid = 1'b1;
      bus.exp_src_data  = 32'hDEAD_BEEF;
    end else if (mdl.size() > 0 && mdl[0].rdy <= cyc) begin
      bus.exp_src_valid = 1'b1;
      bus.exp_src_data  = exp_f(mdl[0].d);
    end else begin
      bus.exp_src_valid = 1'b0;
      bus.exp_src_data  = '0;
    end
    bus.res_ready = res_rdy ? '1 : '0;
  endtask

  task automatic observe();
    int idx;
    sb_t e;
    src_hs         = 1'b0;
    last_req_ready = bus.req_ready;
    last_src_ready = bus.exp_src_ready;
    if (rst) return;
    check("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 1);
    for (int i = 0; i < NR; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        n_acc++;
        sb.push_back('{idx: i, data: exp_f(bus.req_data[i])});
        grant_log.push_back(i);
        rem[i]--;
        seq[i]++;
      end
    end
    if (prev_stall) begin
      check("snk_hold_valid", bus.exp_snk_valid, 1);
      check("snk_hold_data", bus.exp_snk_data, prev_data);
    end
    prev_stall = bus.exp_snk_valid && !bus.exp_snk_ready;
    prev_data  = bus.exp_snk_data;
    if (bus.exp_snk_valid && bus.exp_snk_ready)
      mdl.push_back('{d: bus.exp_snk_data, rdy: cyc + FP_EXP_LATENCY});
    if (bus.exp_src_valid && bus.exp_src_ready) begin
      src_hs = 1'b1;
      if (!inject && mdl.size() > 0) void'(mdl.pop_front());
    end
    if (bus.res_valid != '0) begin
      check("res_valid_onehot", $countones(bus.res_valid), 1);
      idx = 0;
      for (int i = 0; i < NR; i++) if (bus.res_valid[i]) idx = i;
      if (bus.res_ready[idx]) begin
        if (sb.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_idx", idx, e.idx);
          check("res_data", bus.res_data, e.data);
          res_cnt[idx]++;
        end
      end
    end
  endtask

  task automatic pre();
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic post();
    @(posedge clk);
    cyc++;
  endtask

  task automatic tick();
    pre();
    observe();
    post();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy() && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, busy(), 0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    inject  = 1'b0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    sb.delete();
    mdl.delete();
    tick();
    tick();
    rst_req    = 1'b0;
    prev_stall = 1'b0;
    sb.delete();
    mdl.delete();
  endtask

  task automatic check_idle(input string tag);
    pre();
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_snk_valid"}, bus.exp_snk_valid, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_src_ready"}, bus.exp_src_ready, 0);
    check({tag, "_orphan"}, orphan_err, 0);
    check({tag, "_tag_empty"}, dut.u_tag_fifo.empty, 1);
    observe();
    post();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst_req = 1'b1; inject = 1'b0; snk_mode = 1'b0; res_rdy = 1'b1;
    prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; seq[i] = 0; res_cnt[i] = 0; end
    drive();
    repeat (3) tick();
    rst_req = 1'b0;
    check_idle("reset");

    // single requester
    rem[0] = 5;
    drain("single_drain", 200);
    check("single_cnt0", res_cnt[0], 5);
    for (int i = 1; i < NR; i++) check("single_cnt_other", res_cnt[i], 0);

    // fairness: rr_ptr is 1 after the last grant went to requester 0
    grant_log.delete();
    for (int i = 0; i < NR; i++) begin res_cnt[i] = 0; rem[i] = 25; end
    drain("fair_drain", 400);
    check("fair_grants", grant_log.size(), 100);
    if (grant_log.size() > 0) check("fair_first", grant_log[0], 1);
    for (int k = 1; k < grant_log.size(); k++)
      check("fair_order", grant_log[k], (grant_log[k-1] + 1) % NR);
    for (int i = 0; i < NR; i++) check("fair_cnt", res_cnt[i], 25);

    // snk backpressure 1,0,0,1
    snk_mode = 1'b1;
    for (int i = 0; i < NR; i++) res_cnt[i] = 0;
    rem[2] = 6; rem[3] = 6;
    drain("bp_drain", 400);
    check("bp_cnt2", res_cnt[2], 6);
    check("bp_cnt3", res_cnt[3], 6);
    snk_mode = 1'b0;

    // tag FIFO full
    res_rdy = 1'b0;
    base = n_acc;
    for (int i = 0; i < NR; i++) rem[i] = 20;
    repeat (60) tick();
    check("full_acc", n_acc - base, 32);
    check("full_req_ready", last_req_ready, 0);
    check("full_src_block", last_src_ready, 0);
    res_rdy = 1'b1;
    n = 0;
    src_hs = 1'b0;
    while (!src_hs && n < 20) begin tick(); n++; end
    check("full_pop_seen", src_hs, 1);
    check("full_ready_at_pop", last_req_ready, 0);
    tick();
    check("full_resume", last_req_ready != 0, 1);
    drain("full_drain", 600);

    // orphan result
    inject = 1'b1;
    pre();
    check("orphan_res_valid", bus.res_valid, 0);
    check("orphan_src_ready", bus.exp_src_ready, 1);
    observe();
    post();
    inject = 1'b0;
    pre();
    check("orphan_set", orphan_err, 1);
    observe();
    post();
    repeat (3) tick();
    pre();
    check("orphan_sticky", orphan_err, 1);
    observe();
    post();
    do_reset();
    check_idle("orphan_rst");

    // reset with 10 operands outstanding
    res_rdy = 1'b0;
    base = n_acc;
    rem[1] = 10;
    n = 0;
    while ((n_acc - base) < 10 && n < 50) begin tick(); n++; end
    check("mid_issued", n_acc - base, 10);
    do_reset();
    check_idle("mid_rst");
    res_rdy = 1'b1;
    for (int i = 0; i < NR; i++) res_cnt[i] = 0;
    rem[2] = 3;
    drain("post_rst_drain", 200);
    check("post_rst_cnt2", res_cnt[2], 3);
    check("post_rst_orphan", orphan_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_exp_arbiter.md
# fp_exp_arbiter

Round-robin arbiter that shares one `fp_exp_wrap` stream pipeline (17-cycle latency, valid/ready on both sides) between `NUM_REQ` independent requesters. Each accepted operand is tagged with its requester index in an in-order tag FIFO. The matching result is steered back to that requester's result stream. It sits between the per-channel pixel/weight datapaths and the single shared exponent unit.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 32: operand/result width (IEEE-754 single).
- `TAG_DEPTH`, default 32: tag FIFO depth.
  - Power of two, ≥ 18.
  - Bounds operands in flight.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_data`, in, `NUM_REQ`×`DATA_W`: per-requester operand.
- `req_ready`, out, `NUM_REQ`: operand accepted when `req_valid[i] && req_ready[i]`.
- `exp_snk_valid`, out, 1: operand stream to the exponent unit.
- `exp_snk_data`, out, `DATA_W`: operand stream to the exponent unit.
- `exp_snk_ready`, in, 1: exponent unit accepts the operand.
- `exp_src_valid`, in, 1: result stream from the exponent unit.
- `exp_src_data`, in, `DATA_W`: result stream from the exponent unit.
- `exp_src_ready`, out, 1: result accepted from the exponent unit.
- `res_valid`, out, `NUM_REQ`: per-requester result valid.
- `res_data`, out, `DATA_W`: shared result bus; valid only for the asserted `res_valid` bit.
- `res_ready`, in, `NUM_REQ`: per-requester result ready.
- `orphan_err`, out, 1: sticky; a result arrived with the tag FIFO empty.

## Operation
Issue side:
- One output register (OR) drives `exp_snk_valid`/`exp_snk_data`.
- OR loads when empty, or when its current content is taken (`exp_snk_ready`) in the same cycle.
- Grant: combinational round-robin over `req_valid`, searching from `rr_ptr`.
- `req_ready[i] = grant[i] && or_can_load && !tag_full`. At most one bit is ever high.
- On acceptance of requester g:
  - OR ← `req_data[g]`.
  - Push g into the tag FIFO.
  - `rr_ptr` ← (g+1) mod `NUM_REQ`.
- A requester is never granted twice in a row while another requester is valid.

Return side:
- Tag FIFO head h selects the destination requester.
- `res_valid[h] = exp_src_valid && !tag_empty`. All other bits are 0.
- `res_data = exp_src_data`.
- `exp_src_ready = !tag_empty && res_ready[h]`.
- Pop the tag on `exp_src_valid && exp_src_ready`.
- Results return in issue order, so tag order equals result order.

Boundary conditions:
- **Tag FIFO full:** all `req_ready` are 0. Issue resumes the cycle after a pop frees an entry.
- **Simultaneous push and pop:** both take effect; occupancy is unchanged. Push into a full FIFO is legal if a pop occurs in the same cycle.
- **Orphan result:** `exp_src_valid` with the FIFO empty sets `orphan_err`, which stays set until `rst`. `exp_src_ready` is 1 in that case, so the orphan is dropped.
- **Results blocked:** while `res_ready[h]` is low, `exp_src_ready` stays 0 and the exponent unit stalls.
- **No valid requesters:** the grant is idle and `rr_ptr` holds.

## Timing
- Reset values:
  - `req_ready`, `exp_snk_valid`, `res_valid`, `exp_src_ready`, `orphan_err`: 0.
  - OR empty, tag FIFO empty, `rr_ptr` = 0.
- Reset mid-operation discards in-flight tags. The integrator must reset the exponent unit in the same cycle.
- Requester acceptance to `exp_snk_valid`: 1 cycle.
- Return path: 0 cycles (`exp_src` to `res_*` combinational). No combinational path from `res_ready` to `req_ready`.
- Throughput: one operand per cycle across all requesters, sustained while the FIFO is not full.
- `exp_snk_valid`/`exp_snk_data` hold stable until `exp_snk_ready`.

## Configuration
- `FP_EXP_ARB_STATS_EN`:
  - Defined: adds output `grant_cnt` (`NUM_REQ`×32).
    - One free-running counter per requester, incremented on each acceptance, wrapping at 2^32.
    - Reset to 0.
    - Adds output `max_inflight` (clog2(`TAG_DEPTH`)+1 bits): high-water mark of tag FIFO occupancy.
  - Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Package `fp_exp_arb_pkg`:
  - `FP_EXP_LATENCY` = 17.
  - `tag_t` (`logic [$clog2(NUM_REQ_MAX)-1:0]`, `NUM_REQ_MAX` = 8).
  - Function `rr_pick(valid, ptr)` returning a one-hot grant.
- Sub-module `tag_fifo`:
  - Parameterised depth/width, synchronous-reset register FIFO.
  - Outputs `full`/`empty`/`count`.
  - Allows push and pop in the same cycle.

## Test plan
- **Single requester:**
  - Stimulus: `req_valid` = 0001, 5 operands, exp model at 17 cycles.
  - Response: `res_valid[0]` pulses 5 times, data in order, other bits 0.
- **Fairness:**
  - Stimulus: all four requesters continuously valid.
  - Response: grants go 0,1,2,3,0,… and each requester receives exactly 25 of 100 results.
- **Tag FIFO full:**
  - Stimulus: hold `exp_src_ready` low by keeping `res_ready` = 0; keep issuing.
  - Response: exactly 32 acceptances, then `req_ready` = 0. Raising `res_ready` resumes issue one cycle after the first pop.
- **Backpressure:**
  - Stimulus: `exp_snk_ready` toggles 1,0,0,1.
  - Response: `exp_snk_data` stable during stalls, no lost or duplicated operands.
- **Orphan result:**
  - Stimulus: inject `exp_src_valid` with nothing issued.
  - Response: `orphan_err` = 1 next cycle, sticky until `rst`. No `res_valid`.
- **Reset mid-flight:**
  - Stimulus: assert `rst` with 10 operands outstanding.
  - Response: next cycle all outputs at reset values, tag FIFO empty.
